// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : iterative RV32M multiply/divide, 32-step shift-add / restoring
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      C_LAST    = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Operand conditioning for the capture cycle
  logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    a_sgn = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg = a_sgn && a[XLEN-1];
    b_neg = b_sgn && b[XLEN-1];
    abs_a = a_neg ? (~a + 1'b1) : a;
    abs_b = b_neg ? (~b + 1'b1) : b;
    div0  = op[2] && (b == '0);
    ovf   = ((op == 3'd4) || (op == 3'd6)) && (a == C_MIN_NEG) && (b == '1);
  end

  // One iteration of either algorithm plus the final sign fix
  logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, res_final;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_sub = rem_sh - {1'b0, opnd_q};
    prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot    = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem     = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (spec_q)
      res_final = spec_val_q;
    else if (!op_q[2])
      res_final = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      res_final = op_q[1] ? rem : quot;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d       = op;
          cnt_d      = '0;
          neg_d      = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          spec_d     = div0 || ovf;
          // div0: DIV/DIVU all ones, REM/REMU dividend; overflow: MIN_NEG / 0
          if (div0)
            spec_val_d = op[1] ? a : {XLEN{1'b1}};
          else
            spec_val_d = op[1] ? {XLEN{1'b0}} : C_MIN_NEG;
          // Low half holds the multiplier or the dividend bits still to shift in
          acc_d      = {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
          opnd_d     = op[2] ? abs_b : abs_a;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!op_q[2])
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          else if (rem_ge)
            acc_d = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == C_LAST)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = res_final;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter : directed self-checking bench for mdu_iter
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_fail;

  mdu_iter #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op from IDLE and wait for done; inputs scrambled after accept
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int busy_cnt);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    res = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = cyc;
        res = result;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; int bc;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat; int bc;
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
    n_checks++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh got=%h exp=40000000", r); end
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
    n_checks++; if (r !== 32'hC000_0000) begin n_fail++; $display("FAIL mulhsu got=%h exp=c0000000", r); end
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
    n_checks++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulhu got=%h exp=40000000", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mulhu_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; int bc;
    run_op(3'd5, 32'd100, 32'd7, r, lat, bc);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got=%h exp=0000000e", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    run_op(3'd7, 32'd100, 32'd7, r, lat, bc);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got=%h exp=00000002", r); end
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_neg got=%h exp=fffffff2", r); end
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_neg got=%h exp=fffffffe", r); end
  endtask

  // Last result before this is REM -100/7 = 0xFFFFFFFE
  task automatic test_flush();
    logic [31:0] r; int lat; int bc; int seen;
    op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
    n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL flush_result_kept got=%h exp=fffffffe", result); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    // flush wins over start in IDLE
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_priority_busy got=%b exp=0", busy); end
    run_op(3'd0, 32'd3, 32'd4, r, lat, bc);
    n_checks++; if (r !== 32'd12) begin n_fail++; $display("FAIL restart_mul got=%h exp=0000000c", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL restart_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat; int bc;
    run_op(3'd4, 32'd5, 32'd0, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero got=%h exp=ffffffff", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div0_latency got=%0d exp=33", lat); end
    run_op(3'd7, 32'd5, 32'd0, r, lat, bc);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu_by_zero got=%h exp=00000005", r); end
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_by_zero got=%h exp=ffffffff", r); end
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, r, lat, bc);
    n_checks++; if (r !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL rem_neg_by_zero got=%h exp=fffffffb", r); end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow got=%h exp=80000000", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=33", lat); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_overflow got=%h exp=00000000", r); end
  endtask

  // Previous result is nonzero, so the async clear is observable
  task automatic test_async_reset();
    logic [31:0] r; int lat; int bc; int seen;
    run_op(3'd0, 32'd3, 32'd5, r, lat, bc);
    n_checks++; if (r !== 32'd15) begin n_fail++; $display("FAIL pre_reset_mul got=%h exp=0000000f", r); end
    op = 3'd0; a = 32'd6; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL async_reset_result got=%h exp=0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL async_reset_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int n_done; int t1; int t2;
    logic [31:0] r1; logic [31:0] r2;
    n_done = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin t1 = cyc; r1 = result; end
        if (n_done == 2) begin t2 = cyc; r2 = result; end
      end
      if (cyc == 33) begin op = 3'd0; a = 32'd6; b = 32'd7; end
      if (cyc == 34) begin start = 1'b0; op = 3'd1; a = 32'd1; b = 32'd1; end
      if (cyc == 44) begin start = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5; end
      if (cyc == 45) start = 1'b0;
    end
    n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    n_checks++; if (t1 !== 33) begin n_fail++; $display("FAIL b2b_first_time got=%0d exp=33", t1); end
    n_checks++; if (t2 - t1 !== 34) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=34", t2 - t1); end
    n_checks++; if (r1 !== 32'd14) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=0000000e", r1); end
    n_checks++; if (r2 !== 32'd42) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=0000002a", r2); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_flush();
    test_special();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
